// File: rtl/data_ram_pipe_pkg.sv
// Shared definitions for the pipelined data RAM: FSM encoding, byte width
// and the width helpers used to size lane and index fields.
package data_ram_pipe_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int lanes_of(input int data_width);
        return data_width / BYTE_WIDTH;
    endfunction

    // Word index needs at least one bit even for a degenerate depth.
    function automatic int index_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int offset_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 0;
    endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One byte-wide bank of the data RAM: synchronous write, registered read.
module data_ram_lane
    import data_ram_pipe_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [BYTE_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [BYTE_WIDTH-1:0] rdata
);

    logic [BYTE_WIDTH-1:0] mem [DEPTH];

    // Read data is only refreshed on an accepted load, so it holds under back-pressure.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_ram_pipe.sv
// Pipelined byte-lane data RAM with valid/ready request and response ports,
// power-on array clearing and an out-of-range error response.
module data_ram_pipe
    import data_ram_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [lanes_of(DATA_WIDTH)-1:0]    req_select,
    input  logic [DATA_WIDTH-1:0]              req_data,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [DATA_WIDTH-1:0]              resp_data,
    output logic                               resp_err,
    output logic                               busy
);

    localparam int LANES = lanes_of(DATA_WIDTH);
    localparam int IDX_W = index_bits(DEPTH);
    localparam int OFF_W = offset_bits(LANES);

    state_t                 state;
    logic [IDX_W-1:0]       clr_ptr;
    logic                   resp_ok;
    logic [IDX_W-1:0]       req_idx;
    logic                   in_range;
    logic                   accept;
    logic                   load_acc;
    logic                   store_acc;
    logic [LANES-1:0]       lane_we;
    logic [IDX_W-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [DATA_WIDTH-1:0]  rd_data;

    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign in_range = (req_addr >> (OFF_W + IDX_W)) == '0;

    assign busy      = (state == ST_CLEAR);
    assign req_ready = !rst && (state == ST_RUN) && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;
    assign load_acc  = accept && !req_write;
    assign store_acc = accept && req_write;

    // While clearing, the sweep owns every lane's write port.
    assign wr_addr = busy ? clr_ptr : req_idx;
    assign wr_data = busy ? '0 : req_data;
    assign lane_we = busy ? '1 : ({LANES{store_acc && in_range}} & req_select);

    assign resp_data = resp_ok ? rd_data : '0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        data_ram_lane #(
            .DEPTH     (DEPTH),
            .ADDR_BITS (IDX_W)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .waddr (wr_addr),
            .wdata (wr_data[g*BYTE_WIDTH +: BYTE_WIDTH]),
            .re    (load_acc && in_range),
            .raddr (req_idx),
            .rdata (rd_data[g*BYTE_WIDTH +: BYTE_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_ptr    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_ok    <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == IDX_W'(DEPTH - 1))
                    state <= ST_RUN;
            end
            // resp_ok gates the bank output so errors and idle cycles read as zero.
            if (load_acc) begin
                resp_valid <= 1'b1;
                resp_err   <= !in_range;
                resp_ok    <= in_range;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
                resp_ok    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/data_ram_pipe.md
# data_ram_pipe

Parametrised, pipelined successor to the core's single-port data RAM. Byte-lane-enabled synchronous memory behind a valid/ready request port and a registered valid/ready response port, so the MEM stage can stall cleanly. Adds power-on clearing of the whole array, an out-of-range error flag and back-pressure on the response. Sits between the MEM stage and the on-chip data store.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8. `LANES = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32: byte-address width.
- `DEPTH`, 1024: number of words; must be a power of two, ≥ 2.
- `CLEAR_ON_RESET`, 1: 1 = zero the whole array after reset; 0 = skip clearing.
- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted on a cycle where `req_valid && req_ready`.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input ADDR_WIDTH: byte address; low log2(LANES) bits are ignored.
- `req_select` input LANES: byte-lane write enables; bit i covers bits [8i+7:8i].
- `req_data` input DATA_WIDTH: store data.
- `resp_valid` output 1: load response present.
- `resp_ready` input 1: consumer takes the response on `resp_valid && resp_ready`.
- `resp_data` output DATA_WIDTH: load data; all-zero when `resp_err` is set.
- `resp_err` output 1: the load address was out of range.
- `busy` output 1: the clear sequence is running.

## Operation
- Word index = `req_addr[log2(LANES) +: log2(DEPTH)]`.
- Out of range: any set bit of `req_addr` at or above `log2(LANES)+log2(DEPTH)`.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if `CLEAR_ON_RESET`, otherwise RUN.
  - CLEAR writes zero to word `clr_ptr` each cycle, with `clr_ptr` running 0..DEPTH-1.
  - After writing word DEPTH-1 → RUN.
  - `busy = (state == CLEAR)`.
- `req_ready = (state == RUN) && (!resp_valid || resp_ready)`. Stores stall behind an untaken response as well, keeping order strict.
- Accepted store:
  - In range: lanes with `req_select[i]=1` are written on the accepting edge; other lanes keep their value.
  - Out of range: the store is dropped silently.
  - A store generates no response.
- Accepted load:
  - Next cycle `resp_valid=1` with the word data, or zeros with `resp_err=1` if out of range.
  - `req_select` is ignored on loads; the full word is always returned.
- Holding rule: `resp_data` and `resp_err` stay stable while `resp_valid && !resp_ready`.
- `resp_valid` drops the cycle after the response is taken, unless a new load is accepted in that same cycle. Back-to-back loads with `resp_ready=1` stream at one per cycle.
- Reset mid-operation:
  - An in-flight response is discarded.
  - The clear restarts from word 0.
  - Array contents are otherwise unspecified until the clear completes.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_err=0`. `busy=1` if `CLEAR_ON_RESET`, else 0.
- With `CLEAR_ON_RESET=0`, `req_ready` rises the first cycle after `rst` deasserts (if no response is pending).
- Clear: exactly DEPTH cycles after `rst` deasserts. `req_ready` first rises in cycle DEPTH+1.
- Load latency: 1 cycle from the accepting edge to `resp_valid`.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Throughput: one request per cycle when not back-pressured.

## Structure
- Shared package or defines file holds: the FSM state encoding (`ST_CLEAR`, `ST_RUN`), `LANES` and the derived index widths (clog2 helpers), and the byte width constant already used by the core.
- Sub-module `data_ram_lane`: one 8-bit × DEPTH synchronous-write, registered-read bank with write enable. Instantiated LANES times in a generate loop. The clear path drives all lanes' write ports.

## Test plan
- Reset then clear: `DEPTH=16`, `CLEAR_ON_RESET=1`. `busy` stays high for 16 cycles; `req_ready` rises in cycle 17. A load of address 0x3C then returns 0x00000000.
- Byte-lane store: store 0xAABBCCDD to 0x10 with select 4'b1111, then 0x11223344 with select 4'b0101. A load of 0x10 returns 0xAA22CC44 one cycle after acceptance; address 0x13 returns the same word.
- Back-pressure: two loads issued with `resp_ready=0`. The first response is held stable and `req_ready=0`. Raise `resp_ready`; both responses arrive in order on consecutive cycles.
- Out of range: `DEPTH=1024`, store 0xDEADBEEF to 0x1000, then load 0x1000. The load gives `resp_err=1`, `resp_data=0`. A load of 0x0000 is unaffected.
- Streaming: 8 back-to-back loads with `resp_ready=1` complete in 9 cycles with `req_ready` continuously high.
- Mid-operation reset: assert `rst` while `resp_valid=1` and again mid-clear. `resp_valid=0` next cycle, `busy=1`, and the clear runs the full DEPTH cycles again.
